// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_queue
//  Description : Instruction buffer between fetch and decode. Holds up to
//                DEPTH fetched instructions with their PC and branch_id in
//                FIFO order, with valid/ready handshakes on both sides, a
//                full flush on redirect, and combinational RV32I field and
//                immediate extraction of the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int BID_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    // Fetch side
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_instr,
    input  logic [31:0]              enq_pc,
    input  logic [BID_W-1:0]         enq_bid,

    // Decode side
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_instr,
    output logic [31:0]              deq_pc,
    output logic [BID_W-1:0]         deq_bid,
    output logic [$clog2(DEPTH):0]   count,

    // Head-entry decode fields
    output logic [6:0]               opcode,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [31:0]              i_imm,
    output logic [31:0]              s_imm,
    output logic [31:0]              b_imm,
    output logic [31:0]              u_imm,
    output logic [31:0]              j_imm
);

    // Index width and pointer width (one extra wrap bit distinguishes
    // full from empty when the index bits are equal).
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [BID_W-1:0] bid_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_tail_idx;
    logic [PTR_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic [31:0]      w_head_instr;

    assign w_head_idx = head_q[AW-1:0];
    assign w_tail_idx = tail_q[AW-1:0];

    // Occupancy is the pointer difference; modular arithmetic on PTR_W bits
    // handles the wrap bit naturally for power-of-two depths.
    assign w_count = tail_q - head_q;
    assign w_full  = (w_count == PTR_W'(DEPTH));
    assign w_empty = (w_count == '0);

    // Ready is independent of deq_ready: no combinational path from decode
    // back to fetch, at the cost of refusing enqueue when full even if the
    // head is leaving this cycle.
    assign enq_ready  = !w_full && !flush;
    assign deq_valid  = !w_empty && !flush;

    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;

    assign count      = w_count;

    // Pointer next-state: flush collapses both pointers to zero, otherwise
    // each advances on its own handshake.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (w_enq_fire) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (w_deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage: reset clears every entry so the head reads zero out of
    // reset; flush deliberately leaves contents untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                instr_q[e] <= '0;
                pc_q[e]    <= '0;
                bid_q[e]   <= '0;
            end
        end else if (w_enq_fire) begin
            instr_q[w_tail_idx] <= enq_instr;
            pc_q[w_tail_idx]    <= enq_pc;
            bid_q[w_tail_idx]   <= enq_bid;
        end
    end

    // ------------------------------------------------------------------
    // Head entry presentation (not gated by deq_valid; decode qualifies)
    // ------------------------------------------------------------------
    assign w_head_instr = instr_q[w_head_idx];
    assign deq_instr    = w_head_instr;
    assign deq_pc       = pc_q[w_head_idx];
    assign deq_bid      = bid_q[w_head_idx];

    // RV32I field slicing and immediate sign extension of the head word.
    always_comb begin
        opcode = w_head_instr[6:0];
        funct3 = w_head_instr[14:12];
        funct7 = w_head_instr[31:25];
        rs1    = w_head_instr[19:15];
        rs2    = w_head_instr[24:20];
        rd     = w_head_instr[11:7];

        i_imm  = {{21{w_head_instr[31]}}, w_head_instr[30:20]};
        s_imm  = {{21{w_head_instr[31]}}, w_head_instr[30:25],
                  w_head_instr[11:7]};
        b_imm  = {{20{w_head_instr[31]}}, w_head_instr[7],
                  w_head_instr[30:25], w_head_instr[11:8], 1'b0};
        u_imm  = {w_head_instr[31:12], 12'h000};
        j_imm  = {{12{w_head_instr[31]}}, w_head_instr[19:12],
                  w_head_instr[20], w_head_instr[30:21], 1'b0};
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_queue
//  Description : Self-checking bench for instr_queue. A queue-based reference
//                model predicts occupancy, handshakes, head contents and
//                decoded fields; directed scenarios are followed by a
//                randomized traffic phase with occasional flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int BID_W = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic [BID_W-1:0] bid;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_instr;
    logic [31:0]      enq_pc;
    logic [BID_W-1:0] enq_bid;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_instr;
    logic [31:0]      deq_pc;
    logic [BID_W-1:0] deq_bid;
    logic [CW-1:0]    count;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      i_imm;
    logic [31:0]      s_imm;
    logic [31:0]      b_imm;
    logic [31:0]      u_imm;
    logic [31:0]      j_imm;

    instr_queue #(.DEPTH(DEPTH), .BID_W(BID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_instr (enq_instr),
        .enq_pc    (enq_pc),
        .enq_bid   (enq_bid),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .deq_bid   (deq_bid),
        .count     (count),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .i_imm     (i_imm),
        .s_imm     (s_imm),
        .b_imm     (b_imm),
        .u_imm     (u_imm),
        .j_imm     (j_imm)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    entry_t model_q[$];
    bit     zero_head;
    int     max_count = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Immediates rebuilt arithmetically from the instruction-format fields.
    function automatic logic [31:0] ref_i(input logic [31:0] w);
        return 32'($signed(w) >>> 20);
    endfunction
    function automatic logic [31:0] ref_s(input logic [31:0] w);
        logic signed [11:0] v;
        int r;
        v = {w[31:25], w[11:7]};
        r = v;
        return r;
    endfunction
    function automatic logic [31:0] ref_b(input logic [31:0] w);
        logic signed [12:0] v;
        int r;
        v = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        r = v;
        return r;
    endfunction
    function automatic logic [31:0] ref_u(input logic [31:0] w);
        return w & 32'hFFFF_F000;
    endfunction
    function automatic logic [31:0] ref_j(input logic [31:0] w);
        logic signed [20:0] v;
        int r;
        v = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        r = v;
        return r;
    endfunction

    task automatic check_head_word(input logic [31:0] w);
        chk("opcode", 32'(opcode), 32'(w & 32'h7F));
        chk("funct3", 32'(funct3), (w >> 12) & 32'h7);
        chk("funct7", 32'(funct7), w >> 25);
        chk("rs1",    32'(rs1),    (w >> 15) & 32'h1F);
        chk("rs2",    32'(rs2),    (w >> 20) & 32'h1F);
        chk("rd",     32'(rd),     (w >> 7) & 32'h1F);
        chk("i_imm",  i_imm, ref_i(w));
        chk("s_imm",  s_imm, ref_s(w));
        chk("b_imm",  b_imm, ref_b(w));
        chk("u_imm",  u_imm, ref_u(w));
        chk("j_imm",  j_imm, ref_j(w));
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        chk("count",     32'(count),     32'(sz));
        chk("enq_ready", 32'(enq_ready), 32'(sz < DEPTH && !flush));
        chk("deq_valid", 32'(deq_valid), 32'(sz > 0 && !flush));
        if (sz > 0) begin
            chk("deq_instr", deq_instr,     model_q[0].instr);
            chk("deq_pc",    deq_pc,        model_q[0].pc);
            chk("deq_bid",   32'(deq_bid),  32'(model_q[0].bid));
            check_head_word(model_q[0].instr);
        end else if (zero_head) begin
            chk("deq_instr_rst", deq_instr,    32'h0);
            chk("deq_pc_rst",    deq_pc,       32'h0);
            chk("deq_bid_rst",   32'(deq_bid), 32'h0);
            check_head_word(32'h0);
        end
    endtask

    // One clock: check settled outputs, then advance the model by the
    // handshakes the model itself says should fire.
    task automatic step();
        bit ef, df;
        entry_t e;
        #1;
        check_outputs();
        ef = enq_valid && (model_q.size() < DEPTH);
        df = deq_ready && (model_q.size() > 0);
        e.instr = enq_instr;
        e.pc    = enq_pc;
        e.bid   = enq_bid;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            zero_head = 1'b1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            if (df) void'(model_q.pop_front());
            if (ef) begin
                model_q.push_back(e);
                zero_head = 1'b0;
            end
        end
        if (model_q.size() > max_count) max_count = model_q.size();
        @(negedge clk);
    endtask

    task automatic drive(input bit ev, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [BID_W-1:0] bid, input bit dr, input bit fl);
        enq_valid = ev;
        enq_instr = ins;
        enq_pc    = pc;
        enq_bid   = bid;
        deq_ready = dr;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        zero_head = 1'b1;
        step();
        rst = 1'b0;

        // Post-reset state
        #1;
        chk("rst_enq_ready", 32'(enq_ready), 32'h1);
        chk("rst_deq_valid", 32'(deq_valid), 32'h0);
        chk("rst_count",     32'(count),     32'h0);

        // 1: single enqueue, visible next cycle with decoded fields
        drive(1'b1, 32'hFE01_0113, 32'h60, 3'd2, 1'b0, 1'b0);
        step();
        idle();
        #1;
        chk("t1_deq_valid", 32'(deq_valid), 32'h1);
        chk("t1_opcode",    32'(opcode),    32'h13);
        chk("t1_rd",        32'(rd),        32'h2);
        chk("t1_rs1",       32'(rs1),       32'h2);
        chk("t1_funct3",    32'(funct3),    32'h0);
        chk("t1_i_imm",     i_imm,          32'hFFFF_FFE0);
        chk("t1_deq_pc",    deq_pc,         32'h60);
        chk("t1_deq_bid",   32'(deq_bid),   32'h2);
        drive(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        step();

        // 2: fill to full, attempt a 5th, then drain
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h1000_0000 + 32'(k), 32'h100 + 32'(4 * k), 3'(k), 1'b0, 1'b0);
            step();
        end
        idle();
        #1;
        chk("t2_count_full", 32'(count),     32'h4);
        chk("t2_enq_ready",  32'(enq_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_order", deq_instr, 32'h1000_0000 + 32'(k));
            drive(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
            step();
        end
        idle();
        #1;
        chk("t2_count_empty", 32'(count),     32'h0);
        chk("t2_deq_valid",   32'(deq_valid), 32'h0);

        // 3: wrap with mixed stalls (10 entries through a 4-deep queue)
        begin
            int sent = 0;
            int got  = 0;
            for (int c = 0; c < 80 && got < 10; c++) begin
                bit ev, dr;
                ev = (sent < 10) && ($urandom_range(0, 3) != 0);
                dr = ($urandom_range(0, 2) != 0);
                drive(ev, 32'h2000_0000 + 32'(sent), 32'h200 + 32'(sent), 3'(sent), dr, 1'b0);
                #1;
                if (dr && deq_valid) begin
                    chk("t3_order", deq_instr, 32'h2000_0000 + 32'(got));
                    got++;
                end
                if (ev && enq_ready) sent++;
                step();
            end
            chk("t3_all_seen", 32'(got), 32'd10);
        end
        idle();

        // 4: count=2 with simultaneous enq+deq for 3 cycles
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h3000_0000 + 32'(k), 32'h300, 3'(k), 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h3000_0002 + 32'(k), 32'h304, 3'(k), 1'b1, 1'b0);
            #1;
            chk("t4_order", deq_instr, 32'h3000_0000 + 32'(k));
            step();
            #1;
            chk("t4_count", 32'(count), 32'h2);
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
            step();
        end

        // 5: flush at count=3 with enq_valid and deq_ready asserted
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h4000_0000 + 32'(k), 32'h400, 3'(k), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD_BEEF, 32'h444, 3'd7, 1'b1, 1'b1);
        #1;
        chk("t5_enq_ready", 32'(enq_ready), 32'h0);
        chk("t5_deq_valid", 32'(deq_valid), 32'h0);
        step();
        idle();
        #1;
        chk("t5_count", 32'(count), 32'h0);
        drive(1'b1, 32'h5000_0000, 32'h500, 3'd5, 1'b0, 1'b0);
        step();
        idle();
        #1;
        chk("t5_no_ghost", deq_instr, 32'h5000_0000);

        // 6: reset while count=3
        drive(1'b1, 32'h5000_0001, 32'h504, 3'd1, 1'b0, 1'b0);
        step();
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_count",     32'(count),     32'h0);
        chk("t6_deq_valid", 32'(deq_valid), 32'h0);
        chk("t6_deq_instr", deq_instr,      32'h0);
        chk("t6_i_imm",     i_imm,          32'h0);
        chk("t6_j_imm",     j_imm,          32'h0);
        chk("t6_enq_ready", 32'(enq_ready), 32'h1);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, BID_W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();
        chk("max_count", 32'(max_count <= DEPTH), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
